// File: rtl/trig_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// trig_sequencer_pkg
// Shared definitions for the trig calculator front-end sequencer:
//   DATA_WIDTH    width of angle buses (degrees, integer)
//   FP_WIDTH      width of the IEEE-754 double result
//   DEF_MAX_ANGLE default first illegal input angle
//   FUNC_SIN/COS  function select codes
//   state_t       sequencer FSM states
// ---------------------------------------------------------------------------
package trig_sequencer_pkg;

  localparam int DATA_WIDTH    = 10;
  localparam int FP_WIDTH      = 64;
  localparam int DEF_MAX_ANGLE = 720;

  localparam logic FUNC_SIN = 1'b0;
  localparam logic FUNC_COS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REDUCE    = 3'd1,
    ST_EVAL      = 3'd2,
    ST_WAIT_EVAL = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

endpackage

// File: rtl/trig_sequencer_quadrant_mapper.sv
// ---------------------------------------------------------------------------
// trig_sequencer_quadrant_mapper
// Combinational mapping from (requested function, quadrant) to the
// first-quadrant function the evaluation core must compute and whether the
// core's non-negative result has to be negated.
// Ports:
//   func      in  requested function (0 sin, 1 cos)
//   quadrant  in  quadrant from the angle-reduction divider
//   eval_func out function for the evaluation core (0 sin, 1 cos)
//   negate    out result must be negated
// ---------------------------------------------------------------------------
module trig_sequencer_quadrant_mapper
  import trig_sequencer_pkg::*;
(
  input  logic       func,
  input  logic [1:0] quadrant,
  output logic       eval_func,
  output logic       negate
);

  always_comb begin
    eval_func = FUNC_SIN;
    negate    = 1'b0;
    if (func == FUNC_SIN) begin
      case (quadrant)
        2'd0: begin eval_func = FUNC_SIN; negate = 1'b0; end
        2'd1: begin eval_func = FUNC_COS; negate = 1'b0; end
        2'd2: begin eval_func = FUNC_SIN; negate = 1'b1; end
        default: begin eval_func = FUNC_COS; negate = 1'b1; end
      endcase
    end else begin
      case (quadrant)
        2'd0: begin eval_func = FUNC_COS; negate = 1'b0; end
        2'd1: begin eval_func = FUNC_SIN; negate = 1'b1; end
        2'd2: begin eval_func = FUNC_COS; negate = 1'b1; end
        default: begin eval_func = FUNC_SIN; negate = 1'b0; end
      endcase
    end
  end

endmodule

// File: rtl/trig_sequencer.sv
// ---------------------------------------------------------------------------
// trig_sequencer
// Front-end controller for the trig calculator. Accepts one angle request,
// runs it through the angle-reduction divider, dispatches a first-quadrant
// evaluation to the double-precision core, applies quadrant sign correction
// and returns the result through a valid/ready handshake.
//
// Optional feature: define TRIG_SEQ_TIMEOUT_EN to enable an evaluation
// watchdog; after TIMEOUT_CYCLES cycles in WAIT_EVAL without eval_done the
// request completes with out_err=1 and out_result=0.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready          request handshake
//   in_angle, in_func          angle in degrees, 0 = sin / 1 = cos
//   en_divider, div_angle      divider request
//   div_quadrant, div_data     divider response (quadrant, reduced angle)
//   eval_start                 one-cycle start pulse to the evaluation core
//   eval_func, eval_angle      first-quadrant evaluation request
//   eval_done, eval_result     evaluation core response (non-negative double)
//   out_valid/out_ready        result handshake
//   out_result, out_err        final double and error flag
//   busy                       high in any state except IDLE
// ---------------------------------------------------------------------------
module trig_sequencer
  import trig_sequencer_pkg::*;
#(
  parameter int unsigned DIV_LATENCY    = 1,
  parameter int unsigned MAX_ANGLE      = DEF_MAX_ANGLE,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_angle,
  input  logic                  in_func,
  output logic                  en_divider,
  output logic [DATA_WIDTH-1:0] div_angle,
  input  logic [1:0]            div_quadrant,
  input  logic [DATA_WIDTH-1:0] div_data,
  output logic                  eval_start,
  output logic                  eval_func,
  output logic [DATA_WIDTH-1:0] eval_angle,
  input  logic                  eval_done,
  input  logic [FP_WIDTH-1:0]   eval_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FP_WIDTH-1:0]   out_result,
  output logic                  out_err,
  output logic                  busy
);

`ifdef TRIG_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int DCNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // Sign correction: a zero magnitude always yields +0, otherwise the sign
  // bit is flipped when the quadrant demands a negative result.
  function automatic logic [FP_WIDTH-1:0] apply_sign(
    input logic [FP_WIDTH-1:0] value,
    input logic                negate
  );
    logic [FP_WIDTH-1:0] res;
    if (value[FP_WIDTH-2:0] == '0) begin
      res = '0;
    end else begin
      res = {value[FP_WIDTH-1] ^ negate, value[FP_WIDTH-2:0]};
    end
    return res;
  endfunction

  state_t state, state_nxt;

  logic [DCNT_W-1:0]     div_cnt;
  logic [TCNT_W-1:0]     wait_cnt;

  logic [DATA_WIDTH-1:0] angle_p0;
  logic                  func_p0;
  logic [DATA_WIDTH-1:0] reduced_p1;
  logic                  eval_func_p1;
  logic                  negate_p1;
  logic [FP_WIDTH-1:0]   result_p2;
  logic                  err_p2;

  logic                  map_eval_func;
  logic                  map_negate;
  logic                  illegal;
  logic                  div_last;
  logic                  timeout_hit;

  trig_sequencer_quadrant_mapper u_quadrant_mapper (
    .func      (func_p0),
    .quadrant  (div_quadrant),
    .eval_func (map_eval_func),
    .negate    (map_negate)
  );

  assign illegal  = 32'(in_angle) >= MAX_ANGLE;
  assign div_last = (div_cnt == '0);
  // eval_done takes priority over expiry in the same cycle.
  assign timeout_hit = TIMEOUT_EN && !eval_done &&
                       (wait_cnt == TCNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    en_divider = 1'b0;
    div_angle  = '0;
    eval_start = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = illegal ? ST_RESP : ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        en_divider = 1'b1;
        div_angle  = angle_p0;
        if (div_last) begin
          state_nxt = ST_EVAL;
        end
      end
      ST_EVAL: begin
        eval_start = 1'b1;
        state_nxt  = ST_WAIT_EVAL;
      end
      ST_WAIT_EVAL: begin
        if (eval_done || timeout_hit) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt      <= '0;
      wait_cnt     <= '0;
      angle_p0     <= '0;
      func_p0      <= FUNC_SIN;
      reduced_p1   <= '0;
      eval_func_p1 <= FUNC_SIN;
      negate_p1    <= 1'b0;
      result_p2    <= '0;
      err_p2       <= 1'b0;
    end else begin
      case (state)
        // Stage p0: request capture
        ST_IDLE: begin
          if (in_valid) begin
            angle_p0  <= in_angle;
            func_p0   <= in_func;
            div_cnt   <= DCNT_W'(DIV_LATENCY - 1);
            result_p2 <= '0;
            err_p2    <= illegal;
          end
        end
        // Stage p1: divider response and quadrant mapping
        ST_REDUCE: begin
          if (div_last) begin
            reduced_p1   <= div_data;
            eval_func_p1 <= map_eval_func;
            negate_p1    <= map_negate;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        ST_EVAL: begin
          wait_cnt <= '0;
        end
        // Stage p2: result capture with sign correction
        ST_WAIT_EVAL: begin
          if (eval_done) begin
            result_p2 <= apply_sign(eval_result, negate_p1);
            err_p2    <= 1'b0;
          end else if (timeout_hit) begin
            result_p2 <= '0;
            err_p2    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign eval_func  = eval_func_p1;
  assign eval_angle = reduced_p1;
  assign out_result = result_p2;
  assign out_err    = err_p2;

endmodule

// File: tb/tb_trig_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trig_sequencer
// Self-checking bench for trig_sequencer with a divider model, an angle-level
// reference for function swap and sign, and randomized requests.
// Honours TRIG_SEQ_TIMEOUT_EN for the watchdog scenario.
// ---------------------------------------------------------------------------
module tb_trig_sequencer;
  import trig_sequencer_pkg::*;

  localparam int LAT_DIV = 1;
  localparam int TO_CYC  = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_angle;
  logic        in_func;
  logic        en_divider;
  logic [9:0]  div_angle;
  logic [1:0]  div_quadrant;
  logic [9:0]  div_data;
  logic        eval_start;
  logic        eval_func;
  logic [9:0]  eval_angle;
  logic        eval_done;
  logic [63:0] eval_result;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int en_count = 0;

  always #5 clk = ~clk;

  trig_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_angle     (in_angle),
    .in_func      (in_func),
    .en_divider   (en_divider),
    .div_angle    (div_angle),
    .div_quadrant (div_quadrant),
    .div_data     (div_data),
    .eval_start   (eval_start),
    .eval_func    (eval_func),
    .eval_angle   (eval_angle),
    .eval_done    (eval_done),
    .eval_result  (eval_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_err      (out_err),
    .busy         (busy)
  );

  // Divider model: valid while enabled, recognisable junk otherwise.
  always_comb begin
    if (en_divider) begin
      div_quadrant = 2'((div_angle / 10'd90) % 10'd4);
      div_data     = 10'(div_angle % 10'd90);
    end else begin
      div_quadrant = 2'd3;
      div_data     = 10'd77;
    end
  end

  always @(posedge clk) if (en_divider === 1'b1) en_count++;

  // Reference: odd 90-degree sectors swap sin and cos.
  function automatic logic ref_func(input int a, input logic f);
    return (((a / 90) % 2) == 1) ? ~f : f;
  endfunction

  // Reference sign: sin is negative on [180,360), cos on [90,270).
  function automatic logic ref_neg(input int a, input logic f);
    int m;
    m = a % 360;
    if (f == FUNC_SIN) return (m >= 180);
    return (m >= 90) && (m < 270);
  endfunction

  function automatic logic [63:0] ref_out(input logic [63:0] res, input logic neg);
    if (res[62:0] == 63'd0) return 64'd0;
    return neg ? {1'b1, res[62:0]} : res;
  endfunction

  // Full request: accept, divider, evaluation after k cycles, hold, release.
  task automatic do_txn(input int a, input logic f, input int k,
                        input logic [63:0] res, input int hold);
    int cyc;
    int en0;
    logic        bad;
    logic [63:0] exp_res;
    logic        exp_err;
    bad = (a >= 720);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL txn_ready angle=%0d got in_ready=%b want 1", a, in_ready);
    end
    in_angle = 10'(a);
    in_func  = f;
    in_valid = 1'b1;
    en0      = en_count;
    @(negedge clk);
    in_valid = 1'b0;
    cyc      = 1;
    if (bad) begin
      exp_res = 64'd0;
      exp_err = 1'b1;
    end else begin
      exp_res = ref_out(res, ref_neg(a, f));
      exp_err = 1'b0;
      checks++;
      if ({en_divider, div_angle, busy} !== {1'b1, 10'(a), 1'b1}) begin
        errors++;
        $display("FAIL txn_divider angle=%0d got en=%b div_angle=%0d busy=%b want 1 %0d 1",
                 a, en_divider, div_angle, busy, a);
      end
      while (eval_start !== 1'b1 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (cyc !== LAT_DIV + 1) begin
        errors++;
        $display("FAIL txn_start_cycle angle=%0d got %0d want %0d", a, cyc, LAT_DIV + 1);
      end
      checks++;
      if ({eval_func, eval_angle} !== {ref_func(a, f), 10'(a % 90)}) begin
        errors++;
        $display("FAIL txn_eval_req angle=%0d func=%b got f=%b r=%0d want f=%b r=%0d",
                 a, f, eval_func, eval_angle, ref_func(a, f), a % 90);
      end
      for (int j = 1; j <= k; j++) begin
        @(negedge clk);
        cyc++;
        if (j == k) begin
          eval_done   = 1'b1;
          eval_result = res;
        end
      end
      checks++;
      if ({eval_start, eval_func, eval_angle} !== {1'b0, ref_func(a, f), 10'(a % 90)}) begin
        errors++;
        $display("FAIL txn_eval_hold angle=%0d got start=%b f=%b r=%0d", a, eval_start,
                 eval_func, eval_angle);
      end
      @(negedge clk);
      cyc++;
      eval_done   = 1'b0;
      eval_result = {$urandom, $urandom};
      checks++;
      if (cyc !== k + 3) begin
        errors++;
        $display("FAIL txn_latency angle=%0d got %0d want %0d", a, cyc, k + 3);
      end
    end
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if ({out_valid, out_err, out_result, in_ready, busy} !== {1'b1, exp_err, exp_res, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL txn_resp angle=%0d func=%b cyc=%0d got v=%b e=%b r=%h want v=1 e=%b r=%h",
                 a, f, h, out_valid, out_err, out_result, exp_err, exp_res);
      end
      if (h < hold) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL txn_release angle=%0d got v=%b rdy=%b busy=%b want 0 1 0",
               a, out_valid, in_ready, busy);
    end
    if (bad) begin
      checks++;
      if (en_count !== en0) begin
        errors++;
        $display("FAIL txn_no_divider angle=%0d got %0d enables want 0", a, en_count - en0);
      end
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_angle    = '0;
    in_func     = 1'b0;
    eval_done   = 1'b0;
    eval_result = '0;
    out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, en_divider, eval_start, out_valid, out_err, busy} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b en=%b st=%b v=%b e=%b busy=%b", in_ready,
               en_divider, eval_start, out_valid, out_err, busy);
    end
    checks++;
    if ({div_angle, eval_angle, out_result, eval_func} !== 85'd0) begin
      errors++;
      $display("FAIL reset_data got div=%0d ang=%0d res=%h f=%b want 0", div_angle,
               eval_angle, out_result, eval_func);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release got rdy=%b busy=%b v=%b want 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_directed();
    do_txn(30,  FUNC_SIN, 1, 64'h3FE0000000000000, 0);
    do_txn(210, FUNC_SIN, 2, 64'h3FE0000000000000, 1);
    do_txn(120, FUNC_COS, 1, 64'h3FE0000000000000, 0);
    do_txn(90,  FUNC_SIN, 3, 64'h3FF0000000000000, 0);
    do_txn(270, FUNC_COS, 2, 64'h0000000000000000, 0);
    do_txn(180, FUNC_SIN, 1, 64'h3FF0000000000000, 0);
    do_txn(719, FUNC_COS, 1, 64'h3FEFFFFFFFFFFFFF, 0);
  endtask

  task automatic test_illegal();
    do_txn(720,  FUNC_SIN, 1, 64'd0, 5);
    do_txn(1023, FUNC_COS, 1, 64'd0, 0);
  endtask

  task automatic test_reset_abort();
    int n;
    in_angle = 10'd45;
    in_func  = FUNC_SIN;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (eval_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    eval_done   = 1'b1;
    eval_result = 64'h3FE6A09E667F3BCD;
    @(negedge clk);
    eval_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, in_ready, busy, out_result} !== {3'b010, 64'd0}) begin
        errors++;
        $display("FAIL abort_idle cyc=%0d got v=%b rdy=%b busy=%b r=%h want 0 1 0 0",
                 i, out_valid, in_ready, busy, out_result);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wait_eval();
    int n;
    in_angle = 10'd100;
    in_func  = FUNC_COS;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (eval_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    n = 0;
`ifdef TRIG_SEQ_TIMEOUT_EN
    while (out_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({n, out_err, out_result} !== {TO_CYC, 1'b1, 64'd0}) begin
      errors++;
      $display("FAIL timeout_expiry got cycles=%0d e=%b r=%h want %0d 1 0", n, out_err,
               out_result, TO_CYC);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_angle = 10'd100;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (eval_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    repeat (TO_CYC - 1) @(negedge clk);
    eval_done   = 1'b1;
    eval_result = 64'h3FC63A1A7E0B7389;
    @(negedge clk);
    eval_done = 1'b0;
    checks++;
    if ({out_valid, out_err, out_result} !== {2'b10, 64'hBFC63A1A7E0B7389}) begin
      errors++;
      $display("FAIL timeout_race got v=%b e=%b r=%h want 1 0 bfc63a1a7e0b7389",
               out_valid, out_err, out_result);
    end
`else
    for (int i = 0; i < 300; i++) begin
      if (out_valid === 1'b1) n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL no_timeout got %0d valid cycles want 0", n);
    end
    eval_done   = 1'b1;
    eval_result = 64'h3FC63A1A7E0B7389;
    @(negedge clk);
    eval_done = 1'b0;
    checks++;
    if ({out_valid, out_err, out_result} !== {2'b10, 64'hBFC63A1A7E0B7389}) begin
      errors++;
      $display("FAIL late_done got v=%b e=%b r=%h want 1 0 bfc63a1a7e0b7389",
               out_valid, out_err, out_result);
    end
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int a;
    logic f;
    logic [63:0] res;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(720, 1023))
                                      : int'($urandom_range(0, 719));
      f = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        res = 64'd0;
      end else begin
        res = {$urandom, $urandom};
        res[63] = 1'b0;
        if (res[62:0] == 63'd0) res[0] = 1'b1;
      end
      do_txn(a, f, int'($urandom_range(1, 5)), res, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_reset_abort();
    test_wait_eval();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
